pipe_hazard_ctrl: RTL

Parametrised hazard and forwarding controller for the 5-stage RISC-V pipeline. It replaces the fixed one-cycle load-use check with a per-register scoreboard supporting a configurable load latency. It adds a data-memory ready handshake (whole-pipe freeze), a sticky halt state and a saturating stall counter. It sits beside the pipeline registers and drives their stall, flush and enable controls, plus the EX-stage operand forwarding selects.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 24 ++
 rtl/pipe_hazard_ctrl_scoreboard.sv | 42 ++++
 rtl/pipe_hazard_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the hazard/forwarding controller: operand-forward selects
// and the bundle of pipeline-register control strobes.
package pipe_hazard_ctrl_pkg;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic stall_pc;
      logic bubble_idex;
      logic flush_ifid;
      logic flush_idex;
      logic freeze;
   } hazard_ctrl_t;

   // MEM holds the younger result, so it wins over WB.
   function automatic logic [1:0] pick_fwd(input logic mem_hit, input logic wb_hit);
      if (mem_hit) return FWD_MEM;
      if (wb_hit)  return FWD_WB;
      return FWD_REG;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Per-register load scoreboard: a down-counter per architectural register that
// reads nonzero while a load result is still too young to forward.
module hazard_scoreboard
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hold,
   input  logic              load_en,
   input  logic [REG_AW-1:0] load_rd,
   input  logic [REG_AW-1:0] rd_a,
   input  logic [REG_AW-1:0] rd_b,
   output logic              busy_a,
   output logic              busy_b
);

   localparam int NREG  = 2 ** REG_AW;
   localparam int CNT_W = $clog2(LOAD_LAT + 1);

   logic [CNT_W-1:0] cnt [NREG];

   // A fresh load reload overrides the decrement of the same entry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      end else if (!hold) begin
         for (int i = 0; i < NREG; i++) begin
            if (load_en && load_rd == REG_AW'(i))
               cnt[i] <= CNT_W'(LOAD_LAT);
            else if (cnt[i] != '0)
               cnt[i] <= cnt[i] - CNT_W'(1);
         end
      end
   end

   assign busy_a = (cnt[rd_a] != '0);
   assign busy_b = (cnt[rd_b] != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: load-use stalls via
// scoreboard, memory-ready freeze, branch flush, sticky halt and stall counter.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1,
   parameter int PERF_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic [REG_AW-1:0] ex_rs1,
   input  logic [REG_AW-1:0] ex_rs2,
   input  logic              ex_halt,
   input  logic              br_taken,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              mem_regwrite,
   input  logic              wb_regwrite,
   input  logic              mem_req,
   input  logic              mem_ready,
   output logic              stall_pc,
   output logic              bubble_idex,
   output logic              flush_ifid,
   output logic              flush_idex,
   output logic              freeze,
   output logic              halted,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [PERF_W-1:0] stall_cnt
);

   hazard_ctrl_t ctrl;
   logic         busy_1, busy_2;
   logic         load_stall, flush_any, frz, issue, load_en;
   logic         halt_q;
   logic [PERF_W-1:0] perf_q;

   hazard_scoreboard #(
      .REG_AW   (REG_AW),
      .LOAD_LAT (LOAD_LAT)
   ) u_sb (
      .clk     (clk),
      .reset   (reset),
      .hold    (frz),
      .load_en (load_en),
      .load_rd (id_rd),
      .rd_a    (id_rs1),
      .rd_b    (id_rs2),
      .busy_a  (busy_1),
      .busy_b  (busy_2)
   );

   assign frz        = halt_q | (mem_req & ~mem_ready);
   assign flush_any  = br_taken & ~frz;
   assign load_stall = id_valid & ((id_use_rs1 & (id_rs1 != '0) & busy_1) |
                                   (id_use_rs2 & (id_rs2 != '0) & busy_2));
   assign issue      = id_valid & ~load_stall & ~flush_any & ~frz;
   assign load_en    = issue & id_memread & id_regwrite & (id_rd != '0);

   // Priority: freeze over flush over load-use stall.
   always_comb begin
      ctrl             = '0;
      ctrl.freeze      = frz;
      ctrl.flush_ifid  = flush_any;
      ctrl.flush_idex  = flush_any;
      ctrl.stall_pc    = frz | (load_stall & ~flush_any);
      ctrl.bubble_idex = load_stall & ~flush_any & ~frz;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         halt_q <= 1'b0;
      else if (ex_halt & ~frz & ~br_taken)
         halt_q <= 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         perf_q <= '0;
      else if (ctrl.stall_pc && perf_q != '1)
         perf_q <= perf_q + PERF_W'(1);
   end

   // Combinational controls are forced low while reset is held.
   assign stall_pc    = reset & ctrl.stall_pc;
   assign bubble_idex = reset & ctrl.bubble_idex;
   assign flush_ifid  = reset & ctrl.flush_ifid;
   assign flush_idex  = reset & ctrl.flush_idex;
   assign freeze      = reset & ctrl.freeze;
   assign halted      = halt_q;
   assign stall_cnt   = perf_q;

   assign fwd_a = reset ? pick_fwd(mem_regwrite & (mem_rd != '0) & (mem_rd == ex_rs1),
                                   wb_regwrite  & (wb_rd  != '0) & (wb_rd  == ex_rs1))
                        : FWD_REG;
   assign fwd_b = reset ? pick_fwd(mem_regwrite & (mem_rd != '0) & (mem_rd == ex_rs2),
                                   wb_regwrite  & (wb_rd  != '0) & (wb_rd  == ex_rs2))
                        : FWD_REG;

endmodule
